// File: rtl/booth_pkg.sv
// Shared widths and the Booth recoding operation type for the
// sequential radix-2 multiplier.
package booth_pkg;

    localparam int MCAND_W = 8;
    localparam int MPLR_W  = 4;
    localparam int CNT_W   = 3;
    localparam int RES_W   = 8;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_t;

endpackage

// File: rtl/booth_recoder.sv
// Radix-2 Booth recoder: maps the bit pair {Q[k], Q[k-1]}
// onto add, subtract or no-op of the shifted multiplicand.
import booth_pkg::*;

module booth_recoder (
    input  logic      q_k,
    input  logic      q_km1,
    output booth_op_t op
);

    always_comb begin
        op = BOOTH_NOP;
        unique case ({q_k, q_km1})
            2'b01:   op = BOOTH_ADD;
            2'b10:   op = BOOTH_SUB;
            default: op = BOOTH_NOP;
        endcase
    end

endmodule

// File: rtl/booth_multiplier.sv
// Sequential radix-2 Booth multiplier; the caller steps count
// through 0..MPLR_W-1 and the product builds up in acc.
import booth_pkg::*;

module booth_multiplier #(
    parameter int MCAND_W = booth_pkg::MCAND_W,
    parameter int MPLR_W  = booth_pkg::MPLR_W,
    parameter int CNT_W   = booth_pkg::CNT_W,
    parameter int RES_W   = booth_pkg::RES_W
) (
    input  logic               clk,
    input  logic               reset,
    output logic [RES_W-1:0]   result_out,
    input  logic [MCAND_W-1:0] multiplicand,
    input  logic [MPLR_W-1:0]  multiplier,
    input  logic [CNT_W-1:0]   count
);

    logic [MPLR_W:0]  q_ext;
    logic             q_k;
    logic             q_km1;
    logic             active;
    logic             first;
    booth_op_t        op;
    logic [RES_W-1:0] m_ext;
    logic [RES_W-1:0] m_shift;
    logic [RES_W-1:0] addend;
    logic [RES_W-1:0] base;
    logic [RES_W-1:0] acc;

    // Q[-1] is the appended zero at bit 0 of q_ext.
    assign q_ext  = {multiplier, 1'b0};
    assign active = count < CNT_W'(MPLR_W);
    assign first  = count == '0;

    always_comb begin
        q_k   = 1'b0;
        q_km1 = 1'b0;
        for (int i = 0; i < MPLR_W; i++) begin
            if (count == CNT_W'(i)) begin
                q_k   = q_ext[i+1];
                q_km1 = q_ext[i];
            end
        end
    end

    booth_recoder u_recoder (
        .q_k   (q_k),
        .q_km1 (q_km1),
        .op    (op)
    );

    assign m_ext   = RES_W'($signed(multiplicand));
    assign m_shift = m_ext << count;

    always_comb begin
        addend = '0;
        unique case (1'b1)
            op == BOOTH_ADD: addend = m_shift;
            op == BOOTH_SUB: addend = -m_shift;
            default:         addend = '0;
        endcase
    end

    // Step 0 discards any previous product.
    assign base = first ? '0 : acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            acc <= '0;
        end else if (active) begin
            acc <= base + addend;
        end
    end

    assign result_out = acc;

endmodule

// File: tb/tb_booth_multiplier.sv
// Directed-vector bench for booth_multiplier.
// Each scenario task drives steps and checks result_out inline.
module tb_booth_multiplier;

    logic       clk;
    logic       reset;
    logic [7:0] result_out;
    logic [7:0] multiplicand;
    logic [3:0] multiplier;
    logic [2:0] count;

    int checks;
    int errors;

    booth_multiplier dut (
        .clk          (clk),
        .reset        (reset),
        .result_out   (result_out),
        .multiplicand (multiplicand),
        .multiplier   (multiplier),
        .count        (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input logic [7:0] m, input logic [3:0] q,
                        input logic [2:0] k);
        @(negedge clk);
        multiplicand = m;
        multiplier   = q;
        count        = k;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input logic [7:0] m, input logic [3:0] q);
        for (int k = 0; k < 4; k++) step(m, q, 3'(k));
    endtask

    task automatic test_reset;
        reset        = 1'b0;
        multiplicand = 8'h00;
        multiplier   = 4'h0;
        count        = 3'd4;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (result_out !== 8'h00) begin
            errors++;
            $display("FAIL reset: got %h want 00", result_out);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_neg_one;
        run(8'h05, 4'b1111);
        checks++;
        if (result_out !== 8'hFB) begin
            errors++;
            $display("FAIL 5x-1: got %h want FB", result_out);
        end
        step(8'h05, 4'b1111, 3'd4);
        checks++;
        if (result_out !== 8'hFB) begin
            errors++;
            $display("FAIL hold_c4: got %h want FB", result_out);
        end
        step(8'h05, 4'b1111, 3'd5);
        checks++;
        if (result_out !== 8'hFB) begin
            errors++;
            $display("FAIL hold_c5: got %h want FB", result_out);
        end
    endtask

    task automatic test_pos;
        step(8'h05, 4'b0101, 3'd0);
        checks++;
        if (result_out !== 8'hFB) begin
            errors++;
            $display("FAIL 5x5_step0: got %h want FB", result_out);
        end
        for (int k = 1; k < 4; k++) step(8'h05, 4'b0101, 3'(k));
        checks++;
        if (result_out !== 8'h19) begin
            errors++;
            $display("FAIL 5x5: got %h want 19", result_out);
        end
    endtask

    task automatic test_neg_mcand;
        run(8'hFD, 4'b0011);
        checks++;
        if (result_out !== 8'hF7) begin
            errors++;
            $display("FAIL -3x3: got %h want F7", result_out);
        end
    endtask

    task automatic test_edges;
        run(8'h07, 4'b1000);
        checks++;
        if (result_out !== 8'hC8) begin
            errors++;
            $display("FAIL 7x-8: got %h want C8", result_out);
        end
        run(8'h07, 4'b0000);
        checks++;
        if (result_out !== 8'h00) begin
            errors++;
            $display("FAIL 7x0: got %h want 00", result_out);
        end
    endtask

    task automatic test_async_reset;
        for (int k = 0; k < 3; k++) step(8'h05, 4'b0101, 3'(k));
        checks++;
        if (result_out !== 8'hF1) begin
            errors++;
            $display("FAIL pre_reset: got %h want F1", result_out);
        end
        #2;
        reset = 1'b0;
        #1;
        checks++;
        if (result_out !== 8'h00) begin
            errors++;
            $display("FAIL async_clr: got %h want 00", result_out);
        end
        @(negedge clk);
        count = 3'd3;
        @(posedge clk);
        #1;
        checks++;
        if (result_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_held: got %h want 00", result_out);
        end
        @(negedge clk);
        reset = 1'b1;
        run(8'h05, 4'b0101);
        checks++;
        if (result_out !== 8'h19) begin
            errors++;
            $display("FAIL restart: got %h want 19", result_out);
        end
    endtask

    task automatic test_back_to_back;
        run(8'h05, 4'b1111);
        checks++;
        if (result_out !== 8'hFB) begin
            errors++;
            $display("FAIL b2b_first: got %h want FB", result_out);
        end
        step(8'h03, 4'b0010, 3'd0);
        checks++;
        if (result_out !== 8'h00) begin
            errors++;
            $display("FAIL b2b_step0: got %h want 00", result_out);
        end
        for (int k = 1; k < 4; k++) step(8'h03, 4'b0010, 3'(k));
        checks++;
        if (result_out !== 8'h06) begin
            errors++;
            $display("FAIL b2b_second: got %h want 06", result_out);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_neg_one();
        test_pos();
        test_neg_mcand();
        test_edges();
        test_async_reset();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
